// File: rtl/mbist_march_ctrl_if.sv
// Memory-side port of the MBIST controller: one single-port synchronous SRAM access per cycle.
// The controller drives address/command/write data; the macro returns read data one cycle later.
interface mbist_march_ctrl_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 4
);
    logic          mem_rwbar;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (output mem_rwbar, mem_addr, mem_din, input mem_dout);
    modport slave  (input mem_rwbar, mem_addr, mem_din, output mem_dout);
endinterface

// File: rtl/mbist_march_ctrl.sv
// March-test MBIST controller (March C-, MATS+, checkerboard March C-) with functional bypass,
// first-fail capture and a saturating miscompare counter.
module mbist_march_ctrl #(
    parameter int unsigned WCOUNT  = 256,
    parameter int unsigned WLENGTH = 4,
    parameter int unsigned FCW     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic                      rwbarin,
    input  logic [WLENGTH-1:0]        datain,
    input  logic [$clog2(WCOUNT)-1:0] address,
    output logic [WLENGTH-1:0]        dataout,
    mbist_march_ctrl_if.master        mem,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [$clog2(WCOUNT)-1:0] fail_addr,
    output logic [2:0]                fail_elem,
    output logic [FCW-1:0]            fail_count
);
    localparam int unsigned AW = $clog2(WCOUNT);
    localparam logic [AW-1:0] ADDR_MAX = AW'(WCOUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [2:0]         elem_q, elem_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               phase_q, phase_d;
    logic               drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [AW-1:0]      fail_addr_q, fail_addr_d;
    logic [2:0]         fail_elem_q, fail_elem_d;
    logic [FCW-1:0]     fail_count_q, fail_count_d;

    // Read-compare pipeline: s1 = read issued, s2 = read data captured
    logic               s1_vld_q, s1_vld_d;
    logic [WLENGTH-1:0] s1_exp_q, s1_exp_d;
    logic [AW-1:0]      s1_addr_q, s1_addr_d;
    logic [2:0]         s1_elem_q, s1_elem_d;
    logic               s2_vld_q, s2_vld_d;
    logic [WLENGTH-1:0] s2_exp_q, s2_exp_d;
    logic [AW-1:0]      s2_addr_q, s2_addr_d;
    logic [2:0]         s2_elem_q, s2_elem_d;
    logic [WLENGTH-1:0] s2_rdata_q, s2_rdata_d;

    logic               el_down, el_two, el_last;
    logic               op0_rd, op0_val, op1_rd, op1_val;
    logic               op_rd, op_val, addr_last;
    logic [WLENGTH-1:0] bg, op_data;

    function automatic logic elem_is_down(input logic [1:0] m, input logic [2:0] e);
        if (m == 2'b01) return (e == 3'd2);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // Element decode: op count, direction and the read/write + d0/d1 selection per op slot
    always_comb begin
        el_two  = 1'b1;
        el_last = 1'b0;
        op0_rd  = 1'b1;
        op0_val = 1'b0;
        op1_rd  = 1'b0;
        op1_val = 1'b1;
        el_down = elem_is_down(mode_q, elem_q);
        if (mode_q == 2'b01) begin
            case (elem_q)
                3'd0:    begin el_two = 1'b0; op0_rd = 1'b0; end
                3'd1:    ;
                default: begin op0_val = 1'b1; op1_val = 1'b0; el_last = 1'b1; end
            endcase
        end else begin
            case (elem_q)
                3'd0:    begin el_two = 1'b0; op0_rd = 1'b0; end
                3'd1:    ;
                3'd2:    begin op0_val = 1'b1; op1_val = 1'b0; end
                3'd3:    ;
                3'd4:    begin op0_val = 1'b1; op1_val = 1'b0; end
                default: begin el_two = 1'b0; el_last = 1'b1; end
            endcase
        end
    end

    always_comb begin
        bg = '0;
        for (int i = 0; i < int'(WLENGTH); i++) begin
            bg[i] = (mode_q == 2'b10) ? (addr_q[0] ^ i[0]) : 1'b0;
        end
        op_rd     = phase_q ? op1_rd : op0_rd;
        op_val    = phase_q ? op1_val : op0_val;
        op_data   = op_val ? ~bg : bg;
        addr_last = el_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    end

    // Memory port mux: BIST owns the port while busy, otherwise it follows the system inputs
    always_comb begin
        if (busy_q) begin
            mem.mem_rwbar = (state_q == S_RUN) ? op_rd : 1'b1;
            mem.mem_addr  = addr_q;
            mem.mem_din   = op_data;
        end else begin
            mem.mem_rwbar = rwbarin;
            mem.mem_addr  = address;
            mem.mem_din   = datain;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        elem_d       = elem_q;
        addr_d       = addr_q;
        phase_d      = phase_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_count_d = fail_count_q;
        s1_vld_d     = 1'b0;
        s1_exp_d     = op_data;
        s1_addr_d    = addr_q;
        s1_elem_d    = elem_q;
        s2_vld_d     = s1_vld_q;
        s2_exp_d     = s1_exp_q;
        s2_addr_d    = s1_addr_q;
        s2_elem_d    = s1_elem_q;
        s2_rdata_d   = mem.mem_dout;

        if (s2_vld_q && (s2_rdata_q != s2_exp_q)) begin
            if (!fail_q) begin
                fail_d      = 1'b1;
                fail_addr_d = s2_addr_q;
                fail_elem_d = s2_elem_q;
            end
            if (fail_count_q != {FCW{1'b1}}) fail_count_d = fail_count_q + FCW'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    mode_d       = mode;
                    elem_d       = 3'd0;
                    addr_d       = '0;
                    phase_d      = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_elem_d  = 3'd0;
                    fail_count_d = '0;
                end
            end
            S_RUN: begin
                s1_vld_d = op_rd;
                if (el_two && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_last) begin
                        if (el_last) begin
                            state_d = S_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = elem_is_down(mode_q, elem_q + 3'd1) ? ADDR_MAX : '0;
                        end
                    end else begin
                        addr_d = el_down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
                    end
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 2'b00;
            elem_q       <= 3'd0;
            addr_q       <= '0;
            phase_q      <= 1'b0;
            drain_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_count_q <= '0;
            s1_vld_q     <= 1'b0;
            s1_exp_q     <= '0;
            s1_addr_q    <= '0;
            s1_elem_q    <= 3'd0;
            s2_vld_q     <= 1'b0;
            s2_exp_q     <= '0;
            s2_addr_q    <= '0;
            s2_elem_q    <= 3'd0;
            s2_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            elem_q       <= elem_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_count_q <= fail_count_d;
            s1_vld_q     <= s1_vld_d;
            s1_exp_q     <= s1_exp_d;
            s1_addr_q    <= s1_addr_d;
            s1_elem_q    <= s1_elem_d;
            s2_vld_q     <= s2_vld_d;
            s2_exp_q     <= s2_exp_d;
            s2_addr_q    <= s2_addr_d;
            s2_elem_q    <= s2_elem_d;
            s2_rdata_q   <= s2_rdata_d;
        end
    end

    assign dataout    = mem.mem_dout;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_elem  = fail_elem_q;
    assign fail_count = fail_count_q;

endmodule
